// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: instruction word
// layout, FSM state encoding and default geometry.
package core_pkg;

  // Instruction word layout driven onto the core's instruction port.
  localparam int INST_W   = 17;
  localparam int OFIFO_RD = 16;
  localparam int QKADD_HI = 15;
  localparam int QKADD_LO = 12;
  localparam int PADD_HI  = 11;
  localparam int PADD_LO  = 8;
  localparam int EXECUTE  = 7;
  localparam int LOAD     = 6;
  localparam int QMEM_RD  = 5;
  localparam int QMEM_WR  = 4;
  localparam int KMEM_RD  = 3;
  localparam int KMEM_WR  = 2;
  localparam int PMEM_RD  = 1;
  localparam int PMEM_WR  = 0;

  // Default geometry.
  localparam int COL_DEF    = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int GAP_DEF    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP1,
    S_EXEC,
    S_EXEC_END,
    S_GAP2,
    S_DRAIN,
    S_DONE
  } state_e;

  // Counter width able to hold the largest value k ever takes: the last
  // LOAD index, the last gap index, or the full drain row count.
  function automatic int cnt_width(input int col, input int gap, input int addr_w);
    int m;
    m = col + 1;
    if (gap - 1 > m) m = gap - 1;
    if ((1 << addr_w) > m) m = 1 << addr_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/qk_seq_ctrl_if.sv
// Host-side bundle of the sequencer: start/length, output FIFO status,
// idle-time memory-write requests and the generated instruction word.
interface qk_seq_ctrl_if #(
  parameter int addr_w = 4
);
  logic              start;
  logic [addr_w:0]   num_q;
  logic              ofifo_valid;
  logic              host_qwr;
  logic              host_kwr;
  logic [addr_w-1:0] host_add;
  logic [16:0]       inst;
  logic              busy;
  logic              done;

  // Host / upper controller side.
  modport master (
    output start, num_q, ofifo_valid, host_qwr, host_kwr, host_add,
    input  inst, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, num_q, ofifo_valid, host_qwr, host_kwr, host_add,
    output inst, busy, done
  );
endinterface

// File: rtl/qk_seq_ctrl.sv
// Instruction sequencer for the core: LOAD K vectors, EXEC Q vectors,
// DRAIN the output FIFO into psum memory, then a single done pulse.
// While idle it forwards host Q/K memory writes onto the instruction port.
module qk_seq_ctrl
  import core_pkg::*;
#(
  parameter int col    = COL_DEF,
  parameter int addr_w = ADDR_W_DEF,
  parameter int gap    = GAP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  qk_seq_ctrl_if.slave  bus
);

  localparam int              K_W       = cnt_width(col, gap, addr_w);
  localparam logic [K_W-1:0]  K_ONE     = K_W'(1);
  localparam logic [K_W-1:0]  LOAD_LAST = K_W'(col + 1);
  localparam logic [K_W-1:0]  GAP_LAST  = K_W'(gap - 1);
  localparam logic [K_W-1:0]  KMEM_LO   = K_W'(1);
  localparam logic [K_W-1:0]  ADDR_LO   = K_W'(2);
  localparam logic [K_W-1:0]  COL_K     = K_W'(col);
  localparam logic [addr_w:0] NQ_MAX    = (addr_w + 1)'(1 << addr_w);

  state_e            state;
  logic [K_W-1:0]    k;
  logic [addr_w:0]   nq;
  logic [INST_W-1:0] inst_r;
  logic              busy_r;
  logic              done_r;

  logic              start_ok;
  logic [K_W-1:0]    nq_k;
  logic [INST_W-1:0] host_word;

  assign bus.inst = inst_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  assign start_ok = bus.start && (bus.num_q != '0) && (bus.num_q <= NQ_MAX);
  assign nq_k     = K_W'(nq);

  // Idle pass-through word: a simultaneous K write wins over the Q write.
  always_comb begin
    // NOTE: every bit gets a default before the conditional writes, so no latch is inferred.
    host_word                    = '0;
    host_word[KMEM_WR]           = bus.host_kwr;
    host_word[QMEM_WR]           = bus.host_qwr & ~bus.host_kwr;
    host_word[QKADD_HI:QKADD_LO] = bus.host_add;
  end

  // LOAD word for step kk: load throughout, K reads on 1..col, address trails by one.
  function automatic logic [INST_W-1:0] load_word(input logic [K_W-1:0] kk);
    logic [INST_W-1:0] w;
    w       = '0;
    w[LOAD] = 1'b1;
    if (kk >= KMEM_LO && kk <= COL_K) w[KMEM_RD] = 1'b1;
    if (kk >= ADDR_LO && kk <= COL_K) w[QKADD_HI:QKADD_LO] = addr_w'(kk - K_ONE);
    return w;
  endfunction

  // EXEC word for Q vector kk.
  function automatic logic [INST_W-1:0] exec_word(input logic [K_W-1:0] kk);
    logic [INST_W-1:0] w;
    w                    = '0;
    w[EXECUTE]           = 1'b1;
    w[QMEM_RD]           = 1'b1;
    w[QKADD_HI:QKADD_LO] = addr_w'(kk);
    return w;
  endfunction

  // DRAIN word for row kk; read/write strobes only when a row is available.
  function automatic logic [INST_W-1:0] drain_word(input logic [K_W-1:0] kk, input logic acc);
    logic [INST_W-1:0] w;
    w                  = '0;
    w[OFIFO_RD]        = acc;
    w[PMEM_WR]         = acc;
    w[PADD_HI:PADD_LO] = addr_w'(kk);
    return w;
  endfunction

  // Sequencer FSM; every output is registered alongside the state. In DRAIN,
  // k counts rows already accepted, so it also names the next row to write.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values of state and k.
    if (!reset) begin
      state  <= S_IDLE;
      k      <= '0;
      nq     <= '0;
      inst_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state  <= S_LOAD;
            k      <= '0;
            nq     <= bus.num_q;
            inst_r <= load_word('0);
            busy_r <= 1'b1;
          end else begin
            inst_r <= host_word;
          end
        end
        S_LOAD: begin
          if (k == LOAD_LAST) begin
            state  <= S_GAP1;
            k      <= '0;
            inst_r <= '0;
          end else begin
            k      <= k + K_ONE;
            inst_r <= load_word(k + K_ONE);
          end
        end
        S_GAP1: begin
          if (k == GAP_LAST) begin
            state  <= S_EXEC;
            k      <= '0;
            inst_r <= exec_word('0);
          end else begin
            k      <= k + K_ONE;
            inst_r <= '0;
          end
        end
        S_EXEC: begin
          if (k == nq_k - K_ONE) begin
            state  <= S_EXEC_END;
            k      <= '0;
            inst_r <= '0;
          end else begin
            k      <= k + K_ONE;
            inst_r <= exec_word(k + K_ONE);
          end
        end
        S_EXEC_END: begin
          state  <= S_GAP2;
          k      <= '0;
          inst_r <= '0;
        end
        S_GAP2: begin
          if (k == GAP_LAST) begin
            state  <= S_DRAIN;
            k      <= bus.ofifo_valid ? K_ONE : '0;
            inst_r <= drain_word('0, bus.ofifo_valid);
          end else begin
            k      <= k + K_ONE;
            inst_r <= '0;
          end
        end
        S_DRAIN: begin
          if (k == nq_k) begin
            state  <= S_DONE;
            k      <= '0;
            inst_r <= '0;
            done_r <= 1'b1;
          end else begin
            inst_r <= drain_word(k, bus.ofifo_valid);
            if (bus.ofifo_valid) k <= k + K_ONE;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          k      <= '0;
          inst_r <= '0;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          k      <= '0;
          inst_r <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
